core_mem_stage: RTL and testbench

- Consumer end of the execute-stage result interface.
- Accepts one executed instruction at a time: ALU result or effective address, store data, rd, reg_write.
- Runs the data-memory access over a req/gnt/rvalid bus.
- Presents a registered writeback record (rd, reg_write, data) to the WB stage. Loads get byte/halfword extraction; stores get byte-lane steering.

---
 rtl/core_mem_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_core_mem_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_stage.sv
// Memory stage: takes one executed instruction, runs the data-memory access over req/gnt/rvalid,
// and produces a registered writeback record with load extraction and store lane steering.
module core_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic [4:0]      i_rd,
  input  logic            i_reg_write,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_store_data,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic            o_wb_reg_write,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_misaligned
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            is_store_q, is_store_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            mis_q, mis_d;
  logic            accept_s;
  logic            is_ls_s;

  // funct3[1:0]: 00 byte, 01 half, anything else is a word access
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic r;
    case (f3[1:0])
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] r;
    case (f3[1:0])
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = off[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign accept_s = i_valid && (state_q == ST_IDLE);
  assign is_ls_s  = (i_opcode == OP_LOAD) || (i_opcode == OP_STORE);

  // Next-state and writeback record computation
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    funct3_d       = funct3_q;
    is_store_d     = is_store_q;
    rd_d           = rd_q;
    reg_write_d    = reg_write_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_data_d      = wb_data_q;
    mis_d          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && is_ls_s && is_misaligned(i_funct3, i_alu_result[1:0])) begin
          // Dropped access still retires so the pipeline sees exactly one record
          wb_valid_d     = 1'b1;
          mis_d          = 1'b1;
          wb_rd_d        = i_rd;
          wb_reg_write_d = 1'b0;
          wb_data_d      = i_alu_result;
        end else if (accept_s && is_ls_s) begin
          state_d     = ST_REQ;
          addr_d      = i_alu_result;
          funct3_d    = i_funct3;
          is_store_d  = (i_opcode == OP_STORE);
          rd_d        = i_rd;
          reg_write_d = i_reg_write;
          be_d        = store_be(i_funct3, i_alu_result[1:0]);
          wdata_d     = store_wdata(i_funct3, i_store_data);
        end else if (accept_s) begin
          wb_valid_d     = 1'b1;
          wb_rd_d        = i_rd;
          wb_reg_write_d = i_reg_write && (i_rd != 5'd0);
          wb_data_d      = i_alu_result;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_dmem_gnt && is_store_q) begin
          state_d        = ST_IDLE;
          wb_valid_d     = 1'b1;
          wb_rd_d        = rd_q;
          wb_reg_write_d = 1'b0;
        end else if (i_dmem_gnt) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (i_dmem_rvalid) begin
          state_d        = ST_IDLE;
          wb_valid_d     = 1'b1;
          wb_rd_d        = rd_q;
          wb_reg_write_d = reg_write_q && (rd_q != 5'd0);
          wb_data_d      = load_extract(funct3_q, addr_q[1:0], i_dmem_rdata);
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      addr_q         <= {XLEN{1'b0}};
      funct3_q       <= 3'd0;
      is_store_q     <= 1'b0;
      rd_q           <= 5'd0;
      reg_write_q    <= 1'b0;
      be_q           <= 4'd0;
      wdata_q        <= {XLEN{1'b0}};
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= {XLEN{1'b0}};
      mis_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      funct3_q       <= funct3_d;
      is_store_q     <= is_store_d;
      rd_q           <= rd_d;
      reg_write_q    <= reg_write_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_data_q      <= wb_data_d;
      mis_q          <= mis_d;
    end
  end

  assign o_ready        = (state_q == ST_IDLE);
  assign o_dmem_req     = (state_q == ST_REQ);
  assign o_dmem_we      = is_store_q;
  assign o_dmem_addr    = {addr_q[XLEN-1:2], 2'b00};
  assign o_dmem_be      = be_q;
  assign o_dmem_wdata   = wdata_q;
  assign o_wb_valid     = wb_valid_q;
  assign o_wb_rd        = wb_rd_q;
  assign o_wb_reg_write = wb_reg_write_q;
  assign o_wb_data      = wb_data_q;
  assign o_misaligned   = mis_q;

endmodule

// File: tb/tb_core_mem_stage.sv
// Directed self-checking bench for core_mem_stage; inputs change 1 time unit after the
// rising edge and outputs are compared in that same window.
module tb_core_mem_stage;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd;
  logic        i_reg_write;
  logic [31:0] i_alu_result;
  logic [31:0] i_store_data;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_gnt;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic        o_wb_reg_write;
  logic [31:0] o_wb_data;
  logic        o_misaligned;

  int checks = 0;
  int failures = 0;

  core_mem_stage #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_funct3(i_funct3), .i_rd(i_rd), .i_reg_write(i_reg_write),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata), .i_dmem_gnt(i_dmem_gnt),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_reg_write(o_wb_reg_write),
    .o_wb_data(o_wb_data), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_rec(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                           input logic rw, input logic [31:0] alu, input logic [31:0] sd);
    i_valid = 1'b1; i_opcode = op; i_funct3 = f3; i_rd = rd;
    i_reg_write = rw; i_alu_result = alu; i_store_data = sd;
  endtask

  task automatic idle_in();
    i_valid = 1'b0; i_opcode = OP_ALU; i_funct3 = 3'd0; i_rd = 5'd0;
    i_reg_write = 1'b0; i_alu_result = 32'd0; i_store_data = 32'd0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step(); step();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %0h want 1", o_ready); end
    checks++; if ({o_dmem_req, o_dmem_we, o_dmem_be, o_wb_valid, o_wb_reg_write, o_misaligned} !== 9'd0) begin
      failures++; $display("FAIL rst_ctrl: got %b want 0", {o_dmem_req, o_dmem_we, o_dmem_be, o_wb_valid, o_wb_reg_write, o_misaligned}); end
    checks++; if ({o_dmem_addr, o_dmem_wdata, o_wb_data, o_wb_rd} !== 101'd0) begin
      failures++; $display("FAIL rst_data: got %h want 0", {o_dmem_addr, o_dmem_wdata, o_wb_data, o_wb_rd}); end
    i_rst = 1'b0;
    // reset while a load waits for data
    drive_rec(OP_LOAD, 3'b010, 5'd5, 1'b1, 32'h0000_0100, 32'd0);
    step(); idle_in();
    i_dmem_gnt = 1'b1; step(); i_dmem_gnt = 1'b0;
    checks++; if ({o_ready, o_dmem_req} !== 2'b00) begin failures++; $display("FAIL rst_wait_state: got %b want 00", {o_ready, o_dmem_req}); end
    i_rst = 1'b1; step(); step(); i_rst = 1'b0;
    checks++; if ({o_ready, o_dmem_req} !== 2'b10) begin failures++; $display("FAIL rst_abandon: got %b want 10", {o_ready, o_dmem_req}); end
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1234_5678; step(); i_dmem_rvalid = 1'b0;
    checks++; if (o_wb_valid !== 1'b0) begin failures++; $display("FAIL rst_no_wb: got %0h want 0", o_wb_valid); end
    step();
    checks++; if (o_wb_valid !== 1'b0) begin failures++; $display("FAIL rst_no_wb2: got %0h want 0", o_wb_valid); end
    // reset while a store is requesting: request drops the next cycle
    drive_rec(OP_STORE, 3'b010, 5'd0, 1'b0, 32'h0000_0200, 32'h5555_AAAA);
    step(); idle_in();
    checks++; if (o_dmem_req !== 1'b1) begin failures++; $display("FAIL rst_req_pre: got %0h want 1", o_dmem_req); end
    i_rst = 1'b1; step(); i_rst = 1'b0;
    checks++; if ({o_dmem_req, o_ready, o_wb_valid} !== 3'b010) begin failures++; $display("FAIL rst_req_drop: got %b want 010", {o_dmem_req, o_ready, o_wb_valid}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res [3];
    logic [4:0]  rds [3];
    logic        rws [3];
    res[0] = 32'h11; res[1] = 32'h22; res[2] = 32'h33;
    rds[0] = 5'd1;   rds[1] = 5'd2;   rds[2] = 5'd0;
    rws[0] = 1'b1;   rws[1] = 1'b1;   rws[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rec(OP_ALU, 3'd0, rds[i], 1'b1, res[i], 32'd0);
      step();
      checks++; if ({o_wb_valid, o_ready} !== 2'b11) begin failures++; $display("FAIL b2b_valid[%0d]: got %b want 11", i, {o_wb_valid, o_ready}); end
      checks++; if (o_wb_data !== res[i]) begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", i, o_wb_data, res[i]); end
      checks++; if ({o_wb_rd, o_wb_reg_write} !== {rds[i], rws[i]}) begin
        failures++; $display("FAIL b2b_rd_rw[%0d]: got %h/%0h want %h/%0h", i, o_wb_rd, o_wb_reg_write, rds[i], rws[i]); end
    end
    idle_in(); step();
    checks++; if ({o_wb_valid, o_wb_data} !== {1'b0, 32'h33}) begin failures++; $display("FAIL b2b_hold: got %0h/%h want 0/33", o_wb_valid, o_wb_data); end
  endtask

  task automatic test_store_byte();
    drive_rec(OP_STORE, 3'b000, 5'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5);
    step(); idle_in();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({o_dmem_req, o_dmem_we, o_ready, o_wb_valid} !== 4'b1100) begin
        failures++; $display("FAIL sb_req[%0d]: got %b want 1100", i, {o_dmem_req, o_dmem_we, o_ready, o_wb_valid}); end
      checks++; if ({o_dmem_addr, o_dmem_be, o_dmem_wdata} !== {32'h0000_1000, 4'b1000, 32'hA5A5_A5A5}) begin
        failures++; $display("FAIL sb_bus[%0d]: got %h/%b/%h want 00001000/1000/a5a5a5a5", i, o_dmem_addr, o_dmem_be, o_dmem_wdata); end
      if (i == 2) i_dmem_gnt = 1'b1;
      step();
    end
    i_dmem_gnt = 1'b0;
    checks++; if ({o_wb_valid, o_wb_reg_write, o_dmem_req, o_ready} !== 4'b1001) begin
      failures++; $display("FAIL sb_wb: got %b want 1001", {o_wb_valid, o_wb_reg_write, o_dmem_req, o_ready}); end
    step();
    checks++; if (o_wb_valid !== 1'b0) begin failures++; $display("FAIL sb_single: got %0h want 0", o_wb_valid); end
  endtask

  task automatic test_load_extract();
    logic [2:0]  f3 [3];
    logic [31:0] ad [3];
    logic [31:0] rdt [3];
    logic [31:0] exp [3];
    f3[0] = 3'b000; ad[0] = 32'h2001; rdt[0] = 32'h1234_8000; exp[0] = 32'hFFFF_FF80;
    f3[1] = 3'b100; ad[1] = 32'h2001; rdt[1] = 32'h1234_8000; exp[1] = 32'h0000_0080;
    f3[2] = 3'b101; ad[2] = 32'h2002; rdt[2] = 32'h8001_FFFF; exp[2] = 32'h0000_8001;
    for (int i = 0; i < 3; i++) begin
      drive_rec(OP_LOAD, f3[i], 5'd7, 1'b1, ad[i], 32'd0);
      step(); idle_in();
      checks++; if ({o_dmem_req, o_dmem_we, o_dmem_addr} !== {2'b10, 32'h0000_2000}) begin
        failures++; $display("FAIL ld_req[%0d]: got %b/%h want 10/00002000", i, {o_dmem_req, o_dmem_we}, o_dmem_addr); end
      i_dmem_gnt = 1'b1; step(); i_dmem_gnt = 1'b0;
      i_dmem_rvalid = 1'b1; i_dmem_rdata = rdt[i]; step(); i_dmem_rvalid = 1'b0;
      checks++; if ({o_wb_valid, o_wb_reg_write, o_wb_rd} !== {2'b11, 5'd7}) begin
        failures++; $display("FAIL ld_wb[%0d]: got %b want 1100111", i, {o_wb_valid, o_wb_reg_write, o_wb_rd}); end
      checks++; if (o_wb_data !== exp[i]) begin failures++; $display("FAIL ld_data[%0d]: got %h want %h", i, o_wb_data, exp[i]); end
    end
  endtask

  task automatic test_misaligned();
    drive_rec(OP_LOAD, 3'b010, 5'd3, 1'b1, 32'h0000_3002, 32'd0);
    step(); idle_in();
    checks++; if ({o_dmem_req, o_misaligned, o_wb_valid, o_wb_reg_write, o_ready} !== 5'b01101) begin
      failures++; $display("FAIL mis_lw: got %b want 01101", {o_dmem_req, o_misaligned, o_wb_valid, o_wb_reg_write, o_ready}); end
    step();
    checks++; if ({o_dmem_req, o_misaligned, o_wb_valid} !== 3'b000) begin
      failures++; $display("FAIL mis_pulse: got %b want 000", {o_dmem_req, o_misaligned, o_wb_valid}); end
    drive_rec(OP_STORE, 3'b001, 5'd0, 1'b0, 32'h0000_3002, 32'h0000_BEEF);
    step(); idle_in();
    checks++; if ({o_dmem_req, o_dmem_we, o_misaligned, o_dmem_be} !== 7'b1101100) begin
      failures++; $display("FAIL sh_req: got %b want 1101100", {o_dmem_req, o_dmem_we, o_misaligned, o_dmem_be}); end
    checks++; if ({o_dmem_addr, o_dmem_wdata} !== {32'h0000_3000, 32'hBEEF_BEEF}) begin
      failures++; $display("FAIL sh_bus: got %h/%h want 00003000/beefbeef", o_dmem_addr, o_dmem_wdata); end
    i_dmem_gnt = 1'b1; step(); i_dmem_gnt = 1'b0;
    checks++; if ({o_wb_valid, o_wb_reg_write, o_ready} !== 3'b101) begin
      failures++; $display("FAIL sh_wb: got %b want 101", {o_wb_valid, o_wb_reg_write, o_ready}); end
  endtask

  task automatic test_load_latency();
    drive_rec(OP_LOAD, 3'b010, 5'd9, 1'b1, 32'h0000_4000, 32'd0);
    step(); idle_in();
    checks++; if ({o_ready, o_dmem_req} !== 2'b01) begin failures++; $display("FAIL lat_n1: got %b want 01", {o_ready, o_dmem_req}); end
    i_dmem_gnt = 1'b1; step(); i_dmem_gnt = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      checks++; if ({o_ready, o_dmem_req, o_wb_valid} !== 3'b000) begin
        failures++; $display("FAIL lat_wait[N+%0d]: got %b want 000", c, {o_ready, o_dmem_req, o_wb_valid}); end
      step();
    end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL lat_n5: got %0h want 0", o_ready); end
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF; step(); i_dmem_rvalid = 1'b0;
    checks++; if ({o_wb_valid, o_ready, o_wb_rd, o_wb_data} !== {2'b11, 5'd9, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL lat_wb: got %b/%h/%h want 11/09/deadbeef", {o_wb_valid, o_ready}, o_wb_rd, o_wb_data); end
    drive_rec(OP_ALU, 3'd0, 5'd4, 1'b1, 32'h55, 32'd0);
    step(); idle_in();
    checks++; if ({o_wb_valid, o_wb_rd, o_wb_data} !== {1'b1, 5'd4, 32'h55}) begin
      failures++; $display("FAIL lat_next: got %0h/%h/%h want 1/04/00000055", o_wb_valid, o_wb_rd, o_wb_data); end
  endtask

  initial begin
    i_rst = 1'b1; i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
    idle_in();
    test_reset();
    test_back_to_back();
    test_store_byte();
    test_load_extract();
    test_misaligned();
    test_load_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
